// File: rtl/packet_decoder.sv
// Framed command-packet decoder for the UART RX byte stream: validates checksum,
// channel and mode, then commits staged payloads to the pattern-generator outputs.
module packet_decoder #(
    parameter int unsigned DATA_BIT    = 32,
    parameter int unsigned CHAN_NUM    = 8,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [7:0]                  data_i,
    input  logic                        rx_done_tick_i,
    output logic [DATA_BIT-1:0]         output_pattern_o,
    output logic [DATA_BIT-1:0]         freq_pattern_o,
    output logic [$clog2(CHAN_NUM)-1:0] sel_out_o,
    output logic [1:0]                  mode_o,
    output logic                        enable_o,
    output logic                        stop_o,
    output logic [7:0]                  slow_period_o,
    output logic [7:0]                  fast_period_o,
    output logic [7:0]                  repeat_o,
    output logic [7:0]                  cmd_o,
    output logic                        done_tick_o,
    output logic                        err_tick_o,
    output logic [2:0]                  err_code_o
);

    localparam int unsigned NB    = DATA_BIT / 8;
    localparam int unsigned SEL_W = $clog2(CHAN_NUM);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CmdPeriod = 8'h10;
    localparam logic [7:0] CmdFreq   = 8'h11;
    localparam logic [7:0] CmdData   = 8'h12;
    localparam logic [7:0] CmdRepeat = 8'h13;
    localparam logic [7:0] CmdCtrl   = 8'h14;

    localparam logic [2:0] ErrCmd   = 3'd1;
    localparam logic [2:0] ErrSum   = 3'd2;
    localparam logic [2:0] ErrTmo   = 3'd3;
    localparam logic [2:0] ErrChan  = 3'd4;
    localparam logic [2:0] ErrMode  = 3'd5;

    typedef enum logic [1:0] {StIdle, StPayload, StChksum} state_e;

    // Payload byte count per command; zero marks an unknown command.
    function automatic logic [3:0] payload_len(input logic [7:0] c);
        case (c)
            CmdPeriod, CmdRepeat, CmdCtrl: payload_len = 4'd2;
            CmdFreq:                       payload_len = 4'(NB);
            CmdData:                       payload_len = 4'(NB + 1);
            default:                       payload_len = 4'd0;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          sum_q, sum_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [DATA_BIT-1:0] shadow_q, shadow_d;
    logic [7:0]          first_q, first_d;
    logic                first_pend_q, first_pend_d;

    logic [DATA_BIT-1:0] pat_q, pat_d;
    logic [DATA_BIT-1:0] freq_q, freq_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [1:0]          mode_q, mode_d;
    logic                en_q, en_d;
    logic                stop_q, stop_d;
    logic [7:0]          slow_q, slow_d;
    logic [7:0]          fast_q, fast_d;
    logic [7:0]          rep_q, rep_d;
    logic [7:0]          cmd_out_q, cmd_out_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [2:0]          code_q, code_d;

    logic [7:0] sum_all;
    logic [7:0] last_byte;
    logic       chan_cmd;
    logic       chan_bad;
    logic       mode_bad;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        sum_d        = sum_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        shadow_d     = shadow_q;
        first_d      = first_q;
        first_pend_d = first_pend_q;
        pat_d        = pat_q;
        freq_d       = freq_q;
        sel_d        = sel_q;
        mode_d       = mode_q;
        en_d         = en_q;
        stop_d       = stop_q;
        slow_d       = slow_q;
        fast_d       = fast_q;
        rep_d        = rep_q;
        cmd_out_d    = cmd_out_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        code_d       = code_q;

        sum_all   = sum_q + data_i;
        // All payload bytes shift in from the top, so the last one sits in the top byte.
        last_byte = shadow_q[DATA_BIT-1 -: 8];
        chan_cmd  = (cmd_q == CmdData) || (cmd_q == CmdRepeat) || (cmd_q == CmdCtrl);
        chan_bad  = chan_cmd && (32'(first_q) >= CHAN_NUM);
        mode_bad  = (cmd_q == CmdCtrl) && (last_byte[2:1] == 2'b11);

        case (state_q)
            StIdle: begin
                if (rx_done_tick_i) begin
                    if (payload_len(data_i) != 4'd0) begin
                        cmd_d        = data_i;
                        sum_d        = data_i;
                        cnt_d        = payload_len(data_i);
                        tmo_d        = '0;
                        first_pend_d = 1'b1;
                        state_d      = StPayload;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ErrCmd;
                    end
                end
            end
            StPayload: begin
                if (rx_done_tick_i) begin
                    shadow_d = DATA_BIT'({data_i, shadow_q} >> 8);
                    sum_d    = sum_all;
                    cnt_d    = cnt_q - 4'd1;
                    tmo_d    = '0;
                    if (first_pend_q) begin
                        first_d      = data_i;
                        first_pend_d = 1'b0;
                    end
                    if (cnt_q == 4'd1) begin
                        state_d = StChksum;
                    end
                end
            end
            StChksum: begin
                if (rx_done_tick_i) begin
                    state_d = StIdle;
                    tmo_d   = '0;
                    if (sum_all != 8'h00) begin
                        err_d  = 1'b1;
                        code_d = ErrSum;
                    end else if (chan_bad) begin
                        err_d  = 1'b1;
                        code_d = ErrChan;
                    end else if (mode_bad) begin
                        err_d  = 1'b1;
                        code_d = ErrMode;
                    end else begin
                        done_d    = 1'b1;
                        cmd_out_d = cmd_q;
                        case (cmd_q)
                            CmdPeriod: begin
                                slow_d = first_q;
                                fast_d = last_byte;
                            end
                            CmdFreq: freq_d = shadow_q;
                            CmdData: begin
                                pat_d = shadow_q;
                                sel_d = first_q[SEL_W-1:0];
                            end
                            CmdRepeat: begin
                                rep_d = last_byte;
                                sel_d = first_q[SEL_W-1:0];
                            end
                            CmdCtrl: begin
                                en_d   = last_byte[0];
                                mode_d = last_byte[2:1];
                                stop_d = last_byte[3];
                                sel_d  = first_q[SEL_W-1:0];
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A tick in the expiry cycle is handled above and suppresses the timeout.
        if ((state_q == StPayload || state_q == StChksum) && !rx_done_tick_i) begin
            if (tmo_q == TMO_LAST) begin
                err_d    = 1'b1;
                code_d   = ErrTmo;
                state_d  = StIdle;
                tmo_d    = '0;
                shadow_d = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cmd_q        <= '0;
            sum_q        <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            shadow_q     <= '0;
            first_q      <= '0;
            first_pend_q <= 1'b0;
            pat_q        <= '0;
            freq_q       <= '0;
            sel_q        <= '0;
            mode_q       <= '0;
            en_q         <= 1'b0;
            stop_q       <= 1'b0;
            slow_q       <= '0;
            fast_q       <= '0;
            rep_q        <= '0;
            cmd_out_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            shadow_q     <= shadow_d;
            first_q      <= first_d;
            first_pend_q <= first_pend_d;
            pat_q        <= pat_d;
            freq_q       <= freq_d;
            sel_q        <= sel_d;
            mode_q       <= mode_d;
            en_q         <= en_d;
            stop_q       <= stop_d;
            slow_q       <= slow_d;
            fast_q       <= fast_d;
            rep_q        <= rep_d;
            cmd_out_q    <= cmd_out_d;
            done_q       <= done_d;
            err_q        <= err_d;
            code_q       <= code_d;
        end
    end

    assign output_pattern_o = pat_q;
    assign freq_pattern_o   = freq_q;
    assign sel_out_o        = sel_q;
    assign mode_o           = mode_q;
    assign enable_o         = en_q;
    assign stop_o           = stop_q;
    assign slow_period_o    = slow_q;
    assign fast_period_o    = fast_q;
    assign repeat_o         = rep_q;
    assign cmd_o            = cmd_out_q;
    assign done_tick_o      = done_q;
    assign err_tick_o       = err_q;
    assign err_code_o       = code_q;

endmodule

// File: doc/packet_decoder.md
# packet_decoder

Parametrised successor to the UART command decoder. It parses framed command packets from the UART RX byte stream: a command byte, a payload sized from `DATA_BIT`, then a checksum byte. It stages each payload in shadow registers and commits it to the pattern-generator configuration outputs only when the checksum and field checks pass. Unlike the first-generation decoder, it adds per-packet checksums, an inter-byte timeout, channel-range and mode validation, and an error report, all for `CHAN_NUM` channels. It sits between `UART` (`rx_data_o`/`rx_done_tick_o`) and the multi-channel serial-out cores.

## Interface
- `DATA_BIT`, 32: pattern width; must be a multiple of 8, range 8–64.
- `CHAN_NUM`, 8: number of output channels, range 2–256.
- `TIMEOUT_CYC`, 200000: idle clocks allowed between bytes of one packet.
- `clk_i`  input  1  system clock.
- `rst_ni`  input  1  reset; one clock, asynchronous, active-low.
- `data_i`  input  8  received UART byte.
- `rx_done_tick_i`  input  1  one-cycle strobe; `data_i` is valid in that cycle.
- `output_pattern_o`  output  DATA_BIT  committed data pattern.
- `freq_pattern_o`  output  DATA_BIT  committed frequency-select pattern.
- `sel_out_o`  output  $clog2(CHAN_NUM)  channel of the last committed DATA/REPEAT/CTRL packet.
- `mode_o`  output  2  00 one-shot, 01 continuous, 10 repeat.
- `enable_o`, `stop_o`  output  1 each  control flags.
- `slow_period_o`, `fast_period_o`, `repeat_o`  output  8 each.
- `cmd_o`  output  8  command byte of the last committed packet.
- `done_tick_o`  output  1  one-cycle commit strobe.
- `err_tick_o`  output  1  one-cycle error strobe.
- `err_code_o`  output  3  reason for the last error; holds its value until the next error.

## Operation
- Packet format: `cmd`, then payload bytes (multi-byte fields sent LSB first), then `chk`.
- Checksum rule: the 8-bit sum of all packet bytes, `chk` included, must equal 0x00.
- Commands and payloads, with `NB = DATA_BIT/8`:
  - PERIOD 0x10: `slow`, `fast`.
  - FREQ 0x11: NB bytes.
  - DATA 0x12: `chan`, then NB bytes.
  - REPEAT 0x13: `chan`, `times`.
  - CTRL 0x14: `chan`, `ctrl`, where `ctrl[0]`=en, `ctrl[2:1]`=mode, `ctrl[3]`=stop, and `ctrl[7:4]` are ignored.
- States:
  - IDLE: on a tick with a known cmd, latch the cmd, seed the running sum, load the payload byte count, and go to PAYLOAD. On an unknown cmd, raise error 1 and stay in IDLE.
  - PAYLOAD: each tick shifts the byte into shadow storage, adds it to the sum and decrements the count. The tick carrying the last payload byte moves the FSM to CHKSUM.
  - CHKSUM: the tick carrying `chk` evaluates the checks in priority order and always returns to IDLE:
    - sum ≠ 0: error 2.
    - channel ≥ CHAN_NUM: error 4.
    - CTRL with mode = 11: error 5.
    - otherwise commit.
- Commit updates only the fields the command carries, plus `cmd_o`. `sel_out_o` updates only for DATA, REPEAT and CTRL. All other outputs hold.
- Timeout: a counter clears on every tick and increments every clock while in PAYLOAD or CHKSUM. When it reaches `TIMEOUT_CYC`, raise error 3, discard the shadow data and go to IDLE.
- Error codes: 1 unknown cmd, 2 checksum, 3 timeout, 4 channel out of range, 5 reserved mode.

## Timing
- Reset: every output is 0, including `err_code_o` and both ticks. The FSM is in IDLE with the sum and counters cleared. Assertion mid-packet discards the packet immediately.
- Commit latency: the clock edge that samples the `chk` tick also updates the outputs and sets `done_tick_o` high for exactly one cycle. `err_tick_o` follows the same rule for errors 1, 2, 4 and 5.
- Timeout latency: `err_tick_o` asserts exactly `TIMEOUT_CYC` cycles after the last sampled tick.
- Tick and timeout expiry in the same cycle: the byte wins; there is no error and the counter clears.
- `done_tick_o` and `err_tick_o` are never high in the same cycle.
- Ticks are at least 2 cycles apart; no input FIFO is required. Back-to-back packets need no idle gap: a cmd byte may arrive on the first tick after `chk`.
- There is no timeout in IDLE.

## Test plan
All scenarios use `DATA_BIT`=32 and `CHAN_NUM`=8.
- PERIOD 10 14 05 D7 -> `slow_period_o`=0x14, `fast_period_o`=0x05, `cmd_o`=0x10, one `done_tick_o`, all other outputs unchanged.
- FREQ 11 44 33 22 11 45, then DATA 12 05 EE DD CC BB 97 -> `freq_pattern_o`=0x11223344, `output_pattern_o`=0xBBCCDDEE, `sel_out_o`=5, two `done_tick_o` pulses.
- CTRL 14 05 03 E4 -> `mode_o`=01, `enable_o`=1, `stop_o`=0. Then CTRL 14 05 03 E5 -> `err_code_o`=2, outputs still 01/1/0, no `done_tick_o`.
- 10 14 followed by silence -> `err_tick_o` with code 3 exactly `TIMEOUT_CYC` cycles after the 0x14 tick. A following valid PERIOD packet then commits normally.
- Range and mode checks, each producing no commit:
  - REPEAT 13 09 03 E1 -> error 4.
  - CTRL 14 02 06 E4 -> error 5.
  - Lone byte 0x7F -> error 1, FSM stays in IDLE.
- Reset mid-DATA-packet after 3 bytes, then a full valid DATA packet -> outputs 0 during reset, then a clean commit with no stale bytes.
